mux9_1_seq: RTL
===============

Name: mux9_1_seq

Overview:
- Collecting end of the 9-lane round distribution path in CIPHER_UNIT.
- A 1:9 demux fans a bit out to lanes O0..O8 under a 4-bit select SD9. This block is the return path: it sequences a 4-bit select through lanes 0..LAST and gathers the per-lane WIDTH-bit results I0..I8 into one registered output stream.
- It drives the shared select SD9, so the demux and this collector always address the same lane.
- A start/advance/done handshake frames one full pass.

Parameters:
- WIDTH, 128, bit width of each lane input and of Dout.
- LAST, 8, highest lane index visited per pass; legal range 0..8.

Ports:
- clk  input  1  rising-edge clock.
- rst_n  input  1  asynchronous active-low reset.
- start  input  1  begin a pass; sampled only in IDLE.
- adv  input  1  current lane result is valid; capture it and step.
- I0..I8  input  WIDTH each  lane result inputs; lane k maps to select value k.
- SD9  output  4  current lane select; also drives the paired demux select.
- Dout  output  WIDTH  registered captured lane data.
- dout_valid  output  1  one-cycle pulse, Dout holds a new lane result.
- busy  output  1  high while in RUN.
- done  output  1  one-cycle pulse at end of pass.

Behaviour:
- Reset:
  - rst_n low clears asynchronously: state=IDLE, SD9=0, Dout=0, dout_valid=0, busy=0, done=0.
  - Release is synchronous to the next clk edge.
- FSM states: IDLE, RUN, DONE.
- IDLE:
  - SD9=0, busy=0.
  - start=1 -> RUN on the next edge; SD9 stays 0; busy=1 from that cycle.
  - adv is ignored in IDLE.
- RUN:
  - adv=0: hold SD9 and Dout; dout_valid=0.
  - adv=1 with SD9=k: next edge Dout<=Ik and dout_valid=1 for exactly that one cycle.
    - If k<LAST: SD9<=k+1, stay RUN.
    - If k==LAST: SD9<=0, go to DONE.
  - start is ignored in RUN; it never restarts the pass.
- DONE:
  - Lasts one cycle; done=1 and busy=0.
  - The last lane's dout_valid pulse is in the same cycle as done.
  - Next edge -> IDLE unconditionally.
  - start asserted during DONE is ignored; a new start is accepted from the following IDLE cycle.
- Latency:
  - start to first lane selectable: 1 cycle.
  - adv to dout_valid: 1 cycle.
  - Full pass with adv held high: LAST+1 cycles of RUN, then DONE.
- Select range:
  - SD9 only ever takes values 0..LAST.
  - Values 9..15 are never produced, so the paired demux never sees an all-zero-output select.
- Dout persistence:
  - Dout keeps the last captured value through DONE and IDLE until the next capture.
  - Dout is not cleared at start.
- LAST=0: one adv in RUN captures I0 and enters DONE directly.
- Reset mid-pass:
  - Immediate return to IDLE with all outputs at reset values.
  - No done pulse, and no partial-lane dout_valid after reset.
- Input sampling: lane inputs are sampled only on the edge where adv=1; changes at other times have no effect.

Test Plan:
- Reset, then start=1 for 1 cycle, adv held 1, Ik=k+0x10, WIDTH=128, LAST=8:
  - dout_valid pulses 9 consecutive cycles with Dout=0x10..0x18.
  - SD9 steps 0..8.
  - done=1 with the final pulse; busy low afterwards.
- adv toggled 1,0,0,1 during RUN: SD9 holds at 1 through the two idle cycles; second capture returns I1; no dout_valid while adv=0.
- start pulsed again at SD9=4 in RUN, and again in the DONE cycle: no restart and no SD9 change; pass completes normally; a new pass starts only on the next IDLE start.
- rst_n driven low asynchronously between edges with SD9=5: SD9=0, Dout=0, busy=0, done=0 immediately; no done pulse follows.
- LAST=0 build: start, then adv=1 with I0=0xA5 -> Dout=0xA5 with dout_valid=1 and done=1 in the same cycle; SD9 never leaves 0.
- Paired with the 1:9 demux with Din=1: at every RUN cycle exactly one demux output O_SD9 is high, and none is high for any SD9 value above LAST.

Source files
------------

// File: rtl/mux9_1_seq_if.sv
// mux9_1_seq_if
//   Bundles the lane-collector handshake and data signals.
//   master : the side that issues start/adv and presents the lane results
//   slave  : the collector itself (mux9_1_seq)
//   start, adv      : pass framing and per-lane capture request
//   I0..I8          : WIDTH-bit lane results, lane k selected by SD9==k
//   SD9             : current lane select, shared with the paired 1:9 demux
//   Dout/dout_valid : registered captured lane data and its one-cycle strobe
//   busy/done       : pass in progress / one-cycle end-of-pass pulse
interface mux9_1_seq_if #(
  parameter int WIDTH = 128
);
  logic             start;
  logic             adv;
  logic [WIDTH-1:0] I0, I1, I2, I3, I4, I5, I6, I7, I8;
  logic [3:0]       SD9;
  logic [WIDTH-1:0] Dout;
  logic             dout_valid;
  logic             busy;
  logic             done;

  modport master (
    output start, adv, I0, I1, I2, I3, I4, I5, I6, I7, I8,
    input  SD9, Dout, dout_valid, busy, done
  );

  modport slave (
    input  start, adv, I0, I1, I2, I3, I4, I5, I6, I7, I8,
    output SD9, Dout, dout_valid, busy, done
  );
endinterface

// File: rtl/mux9_1_seq.sv
// mux9_1_seq
//   Collecting end of the 9-lane round distribution path. Walks a 4-bit lane
//   select from 0 to LAST, one step per adv, capturing the selected lane
//   result into a registered output stream. The same select drives the
//   paired 1:9 demux so both ends always address the same lane.
// Ports:
//   clk   : rising-edge clock
//   rst_n : asynchronous active-low reset
//   bus   : mux9_1_seq_if.slave (start, adv, I0..I8 in; SD9, Dout,
//           dout_valid, busy, done out)
// Parameters:
//   WIDTH : lane / Dout width
//   LAST  : highest lane index visited per pass (0..8)
module mux9_1_seq #(
  parameter int WIDTH = 128,
  parameter int LAST  = 8
) (
  input logic         clk,
  input logic         rst_n,
  mux9_1_seq_if.slave bus
);

  localparam logic [3:0] LAST_SEL = 4'(LAST);

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    RUN  = 2'd1,
    DONE = 2'd2
  } state_t;

  state_t           state, state_nxt;
  logic [3:0]       sel_p0, sel_nxt;
  logic             cap_p0;
  logic [WIDTH-1:0] lane_p0;
  logic [WIDTH-1:0] dout_p1;
  logic             vld_p1;

  // Stage p0: select current lane; SD9 never leaves 0..LAST, so the
  // default arm is unreachable in normal operation.
  always_comb begin
    lane_p0 = '0;
    case (sel_p0)
      4'd0:    lane_p0 = bus.I0;
      4'd1:    lane_p0 = bus.I1;
      4'd2:    lane_p0 = bus.I2;
      4'd3:    lane_p0 = bus.I3;
      4'd4:    lane_p0 = bus.I4;
      4'd5:    lane_p0 = bus.I5;
      4'd6:    lane_p0 = bus.I6;
      4'd7:    lane_p0 = bus.I7;
      4'd8:    lane_p0 = bus.I8;
      default: lane_p0 = '0;
    endcase
  end

  always_comb begin
    state_nxt = state;
    sel_nxt   = sel_p0;
    cap_p0    = 1'b0;
    case (state)
      IDLE: begin
        sel_nxt = 4'd0;
        if (bus.start) state_nxt = RUN;
      end
      RUN: begin
        // start is deliberately not looked at here: a pass cannot restart.
        if (bus.adv) begin
          cap_p0 = 1'b1;
          if (sel_p0 == LAST_SEL) begin
            sel_nxt   = 4'd0;
            state_nxt = DONE;
          end else begin
            sel_nxt = sel_p0 + 4'd1;
          end
        end
      end
      DONE: begin
        sel_nxt   = 4'd0;
        state_nxt = IDLE;
      end
      default: begin
        sel_nxt   = 4'd0;
        state_nxt = IDLE;
      end
    endcase
  end

  // Stage p1: registered state, select, captured data and its strobe.
  // Dout is cleared by reset but otherwise only changes on a capture, so it
  // persists through DONE/IDLE and across the next start.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state   <= IDLE;
      sel_p0  <= 4'd0;
      vld_p1  <= 1'b0;
      dout_p1 <= '0;
    end else begin
      state  <= state_nxt;
      sel_p0 <= sel_nxt;
      vld_p1 <= cap_p0;
      if (cap_p0) dout_p1 <= lane_p0;
    end
  end

  // busy/done decode the registered state, so they are glitch-free and
  // drop immediately on reset along with the state.
  assign bus.SD9        = sel_p0;
  assign bus.Dout       = dout_p1;
  assign bus.dout_valid = vld_p1;
  assign bus.busy       = (state == RUN);
  assign bus.done       = (state == DONE);

endmodule
